// File: rtl/mon_exp_ctrl_pkg.sv
// Shared definitions for the mon_exp job sequencer:
// FSM state encoding, bram word indices and the operand width check.
package mon_exp_ctrl_pkg;

    // Sequencer states
    typedef enum logic [1:0] {
        ST_IDLE = 2'd0,
        ST_LOAD = 2'd1,
        ST_RUN  = 2'd2,
        ST_RESP = 2'd3
    } state_t;

    // Operand word order in bram, relative to BASE_ADDR
    localparam logic [1:0] A_LO = 2'd0;
    localparam logic [1:0] A_HI = 2'd1;
    localparam logic [1:0] B_LO = 2'd2;
    localparam logic [1:0] B_HI = 2'd3;

    // Width of exponent index and mon_pro iteration count fields
    localparam int IDX_W = 10;

    // An operand must split into exactly two bram words
    function automatic bit width_ok(input int bitlen, input int dbits);
        return bitlen == 2 * dbits;
    endfunction

endpackage

// File: rtl/mon_exp_ctrl_if.sv
// Host-side job bus: request (valid/ready + operands) and response
// (valid/ready + result). The host drives master, the sequencer is slave.
interface mon_exp_ctrl_if
    import mon_exp_ctrl_pkg::*;
#(
    parameter int BITLEN = 1024
);
    logic              req_valid;
    logic              req_ready;
    logic [BITLEN-1:0] req_a;
    logic [BITLEN-1:0] req_b;
    logic [BITLEN-1:0] req_e;
    logic [IDX_W-1:0]  req_e_idx;
    logic [BITLEN-1:0] req_n;
    logic [IDX_W-1:0]  req_mp_count;

    logic              rsp_valid;
    logic              rsp_ready;
    logic [BITLEN:0]   rsp_ans;
    logic              rsp_timeout;

    modport master (
        output req_valid, req_a, req_b, req_e, req_e_idx, req_n, req_mp_count,
        input  req_ready,
        input  rsp_valid, rsp_ans, rsp_timeout,
        output rsp_ready
    );

    modport slave (
        input  req_valid, req_a, req_b, req_e, req_e_idx, req_n, req_mp_count,
        output req_ready,
        output rsp_valid, rsp_ans, rsp_timeout,
        input  rsp_ready
    );

endinterface

// File: rtl/mon_exp_ctrl_wordsel.sv
// Maps the LOAD word counter to a bram port-2 address and data word.
// Purely combinational; the top gates the result with the write enable.
module mon_exp_ctrl_wordsel
    import mon_exp_ctrl_pkg::*;
#(
    parameter int BITLEN    = 1024,
    parameter int ABITS     = 8,
    parameter int DBITS     = 512,
    parameter int BASE_ADDR = 0
) (
    input  logic [1:0]        word_idx,
    input  logic [BITLEN-1:0] a,
    input  logic [BITLEN-1:0] b,
    output logic [ABITS-1:0]  addr,
    output logic [DBITS-1:0]  data
);

    assign addr = ABITS'(BASE_ADDR) + ABITS'(word_idx);

    // Pick the low/high half of A or B for the current word
    always_comb begin
        data = '0;
        case (word_idx)
            A_LO: data = a[DBITS-1:0];
            A_HI: data = a[BITLEN-1:DBITS];
            B_LO: data = b[DBITS-1:0];
            B_HI: data = b[BITLEN-1:DBITS];
        endcase
    end

endmodule

// File: rtl/mon_exp_ctrl.sv
// Job sequencer in front of mon_exp: accepts one job, writes the A/B
// operand words into bram port 2, holds mon_exp start until a fresh stop
// edge (or timeout), then returns the result over the response bus.
module mon_exp_ctrl
    import mon_exp_ctrl_pkg::*;
#(
    parameter int BITLEN      = 1024,
    parameter int ABITS       = 8,
    parameter int DBITS       = 512,
    parameter int BASE_ADDR   = 0,
    parameter int TIMEOUT_CYC = 65535
) (
    input  logic              clk,
    input  logic              rst_n,
    mon_exp_ctrl_if.slave     host,
    output logic              me_start,
    output logic [BITLEN-1:0] me_e,
    output logic [BITLEN-1:0] me_M,
    output logic [IDX_W-1:0]  me_e_idx,
    output logic [IDX_W-1:0]  me_mp_count,
    input  logic              me_stop,
    input  logic [BITLEN:0]   me_ans,
    output logic [ABITS-1:0]  wr_addr2,
    output logic [DBITS-1:0]  wr_data2,
    output logic              wr_en2,
    output logic              busy
);

    if (!width_ok(BITLEN, DBITS)) begin : g_width_chk
        $error("mon_exp_ctrl: BITLEN must equal 2*DBITS");
    end

    // Counter wide enough to reach TIMEOUT_CYC
    localparam int TW = (TIMEOUT_CYC < 2) ? 1 : $clog2(TIMEOUT_CYC + 1);

    state_t            state;
    logic [1:0]        word_cnt;
    logic [BITLEN-1:0] a_q;
    logic [BITLEN-1:0] b_q;
    logic [TW-1:0]     tmo_cnt;
    logic [TW-1:0]     tmo_nxt;
    logic              tmo_hit;
    logic              stop_q;
    logic              stop_rise;

    logic              req_ready_q;
    logic              rsp_valid_q;
    logic [BITLEN:0]   rsp_ans_q;
    logic              rsp_timeout_q;

    logic [ABITS-1:0]  sel_addr;
    logic [DBITS-1:0]  sel_data;

    mon_exp_ctrl_wordsel #(
        .BITLEN    (BITLEN),
        .ABITS     (ABITS),
        .DBITS     (DBITS),
        .BASE_ADDR (BASE_ADDR)
    ) u_wordsel (
        .word_idx (word_cnt),
        .a        (a_q),
        .b        (b_q),
        .addr     (sel_addr),
        .data     (sel_data)
    );

    // Only a low-to-high stop transition completes a job, so a stop left
    // high from the previous run cannot be mistaken for completion.
    assign stop_rise = me_stop && !stop_q;
    assign tmo_nxt   = tmo_cnt + TW'(1);
    assign tmo_hit   = (TIMEOUT_CYC != 0) && (tmo_nxt == TW'(TIMEOUT_CYC));

    // Address/data are forced to zero outside the LOAD write cycles
    assign wr_addr2 = wr_en2 ? sel_addr : '0;
    assign wr_data2 = wr_en2 ? sel_data : '0;

    assign host.req_ready   = req_ready_q;
    assign host.rsp_valid   = rsp_valid_q;
    assign host.rsp_ans     = rsp_ans_q;
    assign host.rsp_timeout = rsp_timeout_q;

    // Sequencer FSM with registered outputs
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            state         <= ST_IDLE;
            req_ready_q   <= 1'b1;
            busy          <= 1'b0;
            me_start      <= 1'b0;
            wr_en2        <= 1'b0;
            rsp_valid_q   <= 1'b0;
            rsp_ans_q     <= '0;
            rsp_timeout_q <= 1'b0;
            a_q           <= '0;
            b_q           <= '0;
            me_e          <= '0;
            me_M          <= '0;
            me_e_idx      <= '0;
            me_mp_count   <= '0;
            word_cnt      <= '0;
            tmo_cnt       <= '0;
            stop_q        <= 1'b0;
        end else begin
            stop_q <= me_stop;
            case (state)
                ST_IDLE: begin
                    if (host.req_valid && req_ready_q) begin
                        a_q         <= host.req_a;
                        b_q         <= host.req_b;
                        me_e        <= host.req_e;
                        me_M        <= host.req_n;
                        me_e_idx    <= host.req_e_idx;
                        me_mp_count <= host.req_mp_count;
                        word_cnt    <= A_LO;
                        wr_en2      <= 1'b1;
                        req_ready_q <= 1'b0;
                        busy        <= 1'b1;
                        state       <= ST_LOAD;
                    end
                end
                ST_LOAD: begin
                    if (word_cnt == B_HI) begin
                        wr_en2  <= 1'b0;
                        tmo_cnt <= '0;
                        state   <= ST_RUN;
                    end else begin
                        word_cnt <= word_cnt + 2'd1;
                    end
                end
                ST_RUN: begin
                    tmo_cnt <= tmo_nxt;
                    if (stop_rise) begin
                        rsp_ans_q     <= me_ans;
                        rsp_timeout_q <= 1'b0;
                        rsp_valid_q   <= 1'b1;
                        me_start      <= 1'b0;
                        state         <= ST_RESP;
                    end else if (tmo_hit) begin
                        rsp_ans_q     <= '0;
                        rsp_timeout_q <= 1'b1;
                        rsp_valid_q   <= 1'b1;
                        me_start      <= 1'b0;
                        state         <= ST_RESP;
                    end else begin
                        me_start <= 1'b1;
                    end
                end
                ST_RESP: begin
                    if (host.rsp_ready) begin
                        rsp_valid_q <= 1'b0;
                        req_ready_q <= 1'b1;
                        busy        <= 1'b0;
                        state       <= ST_IDLE;
                    end
                end
                default: state <= ST_IDLE;
            endcase
        end
    end

endmodule
